key_debounce: RTL and testbench

- Conditions one raw push-button pin for the PIO key input port.
- Synchronises the asynchronous pin to clk, removes contact bounce, and normalises polarity to active-high "pressed".
- Emits single-cycle press and release strobes for optional fabric consumers.
- key_level drives the PIO in_port directly; the PIO's readdata bit 0 then reflects the clean level.

---
 rtl/key_debounce_pkg.sv | 18 +
 rtl/key_debounce_sync2.sv | 26 ++
 rtl/key_debounce.sv | 161 ++++++++++++++++
 tb/tb_key_debounce.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and default constants for the push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } key_state_t;

    localparam int DEF_DEBOUNCE_CYCLES   = 1000000;
    localparam int DEF_LONG_PRESS_CYCLES = 50000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_sync2.sv
// Generic two-flop synchroniser; RESET_VAL sets the flop value held during reset.
module key_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: sync, debounce FSM, press/release strobes.
// Optional long-press strobe built only when KEY_LONG_PRESS_EN is defined.
//
//   state           | meaning
//   ----------------+---------------------------------------------
//   RELEASED        | stable released level accepted
//   CONFIRM_PRESS   | pin reads pressed, counting stable cycles
//   PRESSED         | stable pressed level accepted
//   CONFIRM_RELEASE | pin reads released, counting stable cycles
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int KEY_ACTIVE_LOW    = 1,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int   MAX_CYC = max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
    localparam int   CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic KEY_LOW = (KEY_ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_sync;
    logic             w_s;
    logic             w_state_level;
    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_key_level;
    logic             r_press;
    logic             r_release;

    key_sync2 #(
        .RESET_VAL (KEY_LOW)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (key_raw),
        .o_q     (w_sync)
    );

    assign w_s = w_sync ^ KEY_LOW;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RELEASED: begin
                if (w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = CONFIRM_PRESS;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CONFIRM_PRESS: begin
                if (!w_s) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = RELEASED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = CONFIRM_RELEASE;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CONFIRM_RELEASE: begin
                if (w_s) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Level trails the state by one register so latency is 2+DEBOUNCE_CYCLES.
    assign w_state_level = (r_state == PRESSED) || (r_state == CONFIRM_RELEASE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= RELEASED;
            r_cnt       <= '0;
            r_key_level <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_level <= w_state_level;
            r_press     <= w_state_level & ~r_key_level;
            r_release   <= ~w_state_level & r_key_level;
        end
    end

    assign key_level     = r_key_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_PRESS_CYCLES);

    logic [CNT_W-1:0] r_hold;
    logic             r_long;

    // Counter saturates at the threshold, so the strobe fires once per press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else if (!r_key_level) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= (r_hold == LONG_LAST);
            if (r_hold != LONG_TC) begin
                r_hold <= r_hold + CNT_ONE;
            end
        end
    end

    assign long_press = r_long;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, active-low pin).
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 10;
    localparam int LAT  = 2 + DEB;

    logic clk = 1'b0;
    logic reset_n;
    logic key_raw;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    typedef struct {
        int   cyc;
        logic val;
    } lvl_t;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic done = 1'b0;
    int   press_q[$];
    int   rel_q[$];
    int   long_q[$];
    lvl_t lvl_q[$];

    key_debounce #(
        .DEBOUNCE_CYCLES   (DEB),
        .KEY_ACTIVE_LOW    (1),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_raw       (key_raw),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_lvl(input int c, input logic v);
        lvl_t e;
        e.cyc = c;
        e.val = v;
        lvl_q.push_back(e);
    endtask

    // Level stays low until t, rises at t; strobes expected at t (and t+LONG).
    task automatic expect_press(input int t);
        for (int c = cyc + 1; c < t; c++) push_lvl(c, 1'b0);
        push_lvl(t, 1'b1);
        push_lvl(t + 1, 1'b1);
        press_q.push_back(t);
`ifdef KEY_LONG_PRESS_EN
        long_q.push_back(t + LONG);
`endif
    endtask

    task automatic expect_release(input int t);
        for (int c = cyc + 1; c < t; c++) push_lvl(c, 1'b1);
        push_lvl(t, 1'b0);
        rel_q.push_back(t);
    endtask

    always @(negedge clk) begin
        lvl_t e;
        if (press_pulse && release_pulse) chk("strobe_overlap", 1, 0);

        if (press_pulse) begin
            if (press_q.size() == 0) chk("press_unexpected", 1, 0);
            else chk("press_cycle", cyc, press_q.pop_front());
        end else if (press_q.size() > 0 && press_q[0] <= cyc) begin
            chk("press_missing", cyc, press_q[0]);
            void'(press_q.pop_front());
        end

        if (release_pulse) begin
            if (rel_q.size() == 0) chk("release_unexpected", 1, 0);
            else chk("release_cycle", cyc, rel_q.pop_front());
        end else if (rel_q.size() > 0 && rel_q[0] <= cyc) begin
            chk("release_missing", cyc, rel_q[0]);
            void'(rel_q.pop_front());
        end

        if (long_press) begin
            if (long_q.size() == 0) chk("long_unexpected", 1, 0);
            else chk("long_cycle", cyc, long_q.pop_front());
        end else if (long_q.size() > 0 && long_q[0] <= cyc) begin
            chk("long_missing", cyc, long_q[0]);
            void'(long_q.pop_front());
        end

        while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
            e = lvl_q.pop_front();
            chk("key_level", int'(key_level), int'(e.val));
        end

        if (done) begin
            chk("press_left", press_q.size(), 0);
            chk("release_left", rel_q.size(), 0);
            chk("long_left", long_q.size(), 0);
            chk("level_left", lvl_q.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    initial begin
        int n;
        key_raw = 1'b1;
        reset_n = 1'b0;
        for (int i = 1; i <= 3; i++) push_lvl(i, 1'b0);
        tick(3);
        reset_n = 1'b1;
        for (int i = 1; i <= 20; i++) push_lvl(cyc + i, 1'b0);
        tick(20);

        // clean press, held long enough for a long-press
        key_raw = 1'b0;
        n = cyc + 1;
        expect_press(n + LAT);
        tick(30);

        key_raw = 1'b1;
        n = cyc + 1;
        expect_release(n + LAT);
        tick(12);

        // bounce: low 3, high 1, then low
        for (int i = 1; i <= 4; i++) push_lvl(cyc + i, 1'b0);
        key_raw = 1'b0;
        tick(3);
        key_raw = 1'b1;
        tick(1);
        key_raw = 1'b0;
        n = cyc + 1;
        expect_press(n + LAT);
        tick(25);

        key_raw = 1'b1;
        n = cyc + 1;
        expect_release(n + LAT);
        tick(12);

        // reset during CONFIRM_PRESS with the pin held pressed
        key_raw = 1'b0;
        tick(3);
        reset_n = 1'b0;
        push_lvl(cyc + 1, 1'b0);
        tick(1);
        reset_n = 1'b1;
        n = cyc + 1;
        expect_press(n + LAT);
        tick(25);

        // reset during CONFIRM_RELEASE: level drops, no release strobe
        key_raw = 1'b1;
        tick(3);
        reset_n = 1'b0;
        push_lvl(cyc + 1, 1'b0);
        tick(1);
        reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) push_lvl(cyc + i, 1'b0);
        tick(12);

        done = 1'b1;
        tick(5);
        $display("FAIL watchdog: got no summary, expected finish");
        $fatal(1, "bench did not finish");
    end

endmodule
